// File: rtl/fir_xifu_pkg.sv
// -----------------------------------------------------------------------------
// fir_xifu_pkg
// Shared types and helpers for the FIR XIFU offload path: command encodings,
// the issuer FSM state type, the abstract command record, and the two
// instruction-format encoders (I-type for loads, S-type for stores).
// -----------------------------------------------------------------------------
package fir_xifu_pkg;

   localparam logic [6:0] XIFU_OPCODE = 7'b1011011;

   localparam logic [2:0] F3_LDTAP = 3'b000;
   localparam logic [2:0] F3_LDSAM = 3'b001;
   localparam logic [2:0] F3_STSAM = 3'b010;

   typedef enum logic [1:0] {
      INSTR_LDTAP   = 2'b00,
      INSTR_LDSAM   = 2'b01,
      INSTR_INVALID = 2'b10,
      INSTR_STSAM   = 2'b11
   } fir_xifu_instr_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ISSUE  = 2'b01,
      ST_COMMIT = 2'b10
   } fir_xifu_issuer_state_t;

   typedef struct packed {
      fir_xifu_instr_t instr;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [11:0]     offset;
      logic [31:0]     rs1_val;
      logic [31:0]     rs2_val;
   } fir_xifu_cmd_t;

   function automatic logic [31:0] xifu_encode_I(input logic [2:0]  funct3,
                                                 input logic [4:0]  rd,
                                                 input logic [4:0]  rs1,
                                                 input logic [11:0] imm);
      return {imm, rs1, funct3, rd, XIFU_OPCODE};
   endfunction

   function automatic logic [31:0] xifu_encode_S(input logic [2:0]  funct3,
                                                 input logic [4:0]  rs1,
                                                 input logic [4:0]  rs2,
                                                 input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, funct3, imm[4:0], XIFU_OPCODE};
   endfunction

endpackage

// File: rtl/fir_xifu_issuer_fifo.sv
// -----------------------------------------------------------------------------
// fir_xifu_issuer_fifo
// Command queue for the issuer. DEPTH == 1 builds a single holding register;
// larger (power-of-2) depths build a circular buffer. Push and pop in the same
// cycle are allowed; the producer must not push while full_o is high.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   push_i, wdata_i     write strobe and command
//   pop_i, rdata_o      read strobe and head-of-queue command
//   full_o, empty_o     occupancy flags
// -----------------------------------------------------------------------------
module fir_xifu_issuer_fifo
   import fir_xifu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  fir_xifu_cmd_t wdata_i,
   input  logic          pop_i,
   output fir_xifu_cmd_t rdata_o,
   output logic          full_o,
   output logic          empty_o
);

   generate
      if (DEPTH == 1) begin : g_hold
         logic          full_q, full_d;
         fir_xifu_cmd_t data_q;

         always_comb begin
            full_d = full_q;
            if (pop_i)  full_d = 1'b0;
            if (push_i) full_d = 1'b1;
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) full_q <= 1'b0;
            else       full_q <= full_d;
         end

         always_ff @(posedge clk_i) begin
            if (push_i) data_q <= wdata_i;
         end

         assign rdata_o = data_q;
         assign full_o  = full_q;
         assign empty_o = !full_q;
      end else begin : g_ring
         localparam int unsigned PTR_W = $clog2(DEPTH);

         fir_xifu_cmd_t    mem_q [DEPTH];
         logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
         logic [PTR_W:0]   cnt_q, cnt_d;

         always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (push_i) wptr_d = wptr_q + PTR_W'(1);
            if (pop_i)  rptr_d = rptr_q + PTR_W'(1);
            case ({push_i, pop_i})
               2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
               2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
               default: cnt_d = cnt_q;
            endcase
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               wptr_q <= '0;
               rptr_q <= '0;
               cnt_q  <= '0;
            end else begin
               wptr_q <= wptr_d;
               rptr_q <= rptr_d;
               cnt_q  <= cnt_d;
            end
         end

         always_ff @(posedge clk_i) begin
            if (push_i) mem_q[wptr_q] <= wdata_i;
         end

         assign rdata_o = mem_q[rptr_q];
         assign full_o  = (cnt_q == (PTR_W + 1)'(DEPTH));
         assign empty_o = (cnt_q == '0);
      end
   endgenerate

endmodule

// File: rtl/fir_xifu_issuer.sv
// -----------------------------------------------------------------------------
// fir_xifu_issuer
// Core-side initiator for the FIR extension unit. Queues abstract FIR commands,
// encodes them as custom-opcode instructions and drives the X-interface issue,
// commit and result channels, so the XIFU can run without a CPU.
//
// Build option: FIR_XIFU_ISSUER_FIFO_EN
//   defined   -> command queue of FIFO_DEPTH entries
//   undefined -> single holding register (FIFO_DEPTH has no effect)
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_*                        command input handshake and fields
//   issue_*                      X-interface issue channel (instr, id, operands)
//   commit_*                     commit channel, one-cycle pulse per accept
//   result_*                     result channel (always ready)
//   rf_we_o/rf_waddr_o/rf_wdata_o  register-file write, one cycle after result
//   rejected_o, err_o            single-cycle status pulses
//   busy_o                       queue non-empty, FSM active or results pending
// -----------------------------------------------------------------------------
module fir_xifu_issuer
   import fir_xifu_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned ID_WIDTH        = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [1:0]          cmd_instr_i,
   input  logic [4:0]          cmd_rs1_i,
   input  logic [4:0]          cmd_rs2_i,
   input  logic [4:0]          cmd_rd_i,
   input  logic [11:0]         cmd_offset_i,
   input  logic [31:0]         cmd_rs1_val_i,
   input  logic [31:0]         cmd_rs2_val_i,
   output logic                issue_valid_o,
   input  logic                issue_ready_i,
   output logic [31:0]         issue_instr_o,
   output logic [ID_WIDTH-1:0] issue_id_o,
   output logic [31:0]         issue_rs1_o,
   output logic [31:0]         issue_rs2_o,
   input  logic                issue_accept_i,
   output logic                commit_valid_o,
   output logic [ID_WIDTH-1:0] commit_id_o,
   output logic                commit_kill_o,
   input  logic                result_valid_i,
   output logic                result_ready_o,
   input  logic [ID_WIDTH-1:0] result_id_i,
   input  logic [4:0]          result_rd_i,
   input  logic                result_we_i,
   input  logic [31:0]         result_data_i,
   output logic                rf_we_o,
   output logic [4:0]          rf_waddr_o,
   output logic [31:0]         rf_wdata_o,
   output logic                rejected_o,
   output logic                err_o,
   output logic                busy_o
);

   localparam int unsigned OUT_W = ID_WIDTH + 1;

`ifdef FIR_XIFU_ISSUER_FIFO_EN
   localparam int unsigned CMD_DEPTH = FIFO_DEPTH;
`else
   // Collapses to a single holding register whatever FIFO_DEPTH is.
   localparam int unsigned CMD_DEPTH = FIFO_DEPTH / FIFO_DEPTH;
`endif

   fir_xifu_issuer_state_t state_q, state_d;
   logic [ID_WIDTH-1:0]    id_q, id_d;
   logic [ID_WIDTH-1:0]    commit_id_q, commit_id_d;
   logic [OUT_W-1:0]       out_q, out_d;
   fir_xifu_cmd_t          iss_q, iss_d;
   logic                   rejected_q, rejected_d;
   logic                   err_q, err_d;
   logic                   rf_we_q, rf_we_d;
   logic [4:0]             rf_waddr_q, rf_waddr_d;
   logic [31:0]            rf_wdata_q, rf_wdata_d;

   logic          fifo_full, fifo_empty, pop, accepted, result_ok;
   fir_xifu_cmd_t cmd_in, fifo_rdata;
   logic [31:0]   issue_instr;

   // Results retire in order, so the returned ID is not tracked.
   logic unused_result_id;
   assign unused_result_id = ^result_id_i;

   assign cmd_in = '{instr:   fir_xifu_instr_t'(cmd_instr_i),
                     rs1:     cmd_rs1_i,
                     rs2:     cmd_rs2_i,
                     rd:      cmd_rd_i,
                     offset:  cmd_offset_i,
                     rs1_val: cmd_rs1_val_i,
                     rs2_val: cmd_rs2_val_i};

   fir_xifu_issuer_fifo #(
      .DEPTH (CMD_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (cmd_valid_i && !fifo_full),
      .wdata_i (cmd_in),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      commit_id_d = commit_id_q;
      iss_d       = iss_q;
      out_d       = out_q;
      rejected_d  = 1'b0;
      err_d       = 1'b0;
      pop         = 1'b0;
      accepted    = 1'b0;
      rf_waddr_d  = result_rd_i;
      rf_wdata_d  = result_data_i;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && (out_q < OUT_W'(MAX_OUTSTANDING))) begin
               pop   = 1'b1;
               iss_d = fifo_rdata;
               // Invalid commands are dropped here and never reach the bus.
               if (fifo_rdata.instr == INSTR_INVALID) err_d   = 1'b1;
               else                                   state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (issue_ready_i) begin
               id_d = id_q + ID_WIDTH'(1);
               if (issue_accept_i) begin
                  accepted    = 1'b1;
                  commit_id_d = id_q;
                  state_d     = ST_COMMIT;
               end else begin
                  rejected_d = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
         end
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // A result with nothing outstanding is stray: ignore it and flag it.
      result_ok = result_valid_i && (out_q != '0);
      if (result_valid_i && (out_q == '0)) err_d = 1'b1;

      case ({accepted, result_ok})
         2'b10:   out_d = out_q + OUT_W'(1);
         2'b01:   out_d = out_q - OUT_W'(1);
         default: out_d = out_q;
      endcase

      rf_we_d = result_ok && result_we_i && (result_rd_i != 5'd0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         id_q       <= '0;
         out_q      <= '0;
         rejected_q <= 1'b0;
         err_q      <= 1'b0;
         rf_we_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         out_q      <= out_d;
         rejected_q <= rejected_d;
         err_q      <= err_d;
         rf_we_q    <= rf_we_d;
      end
   end

   always_ff @(posedge clk_i) begin
      iss_q       <= iss_d;
      commit_id_q <= commit_id_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
   end

   always_comb begin
      case (iss_q.instr)
         INSTR_LDTAP: issue_instr = xifu_encode_I(F3_LDTAP, iss_q.rd, iss_q.rs1, iss_q.offset);
         INSTR_LDSAM: issue_instr = xifu_encode_I(F3_LDSAM, iss_q.rd, iss_q.rs1, iss_q.offset);
         INSTR_STSAM: issue_instr = xifu_encode_S(F3_STSAM, iss_q.rs1, iss_q.rs2, iss_q.offset);
         default:     issue_instr = '0;
      endcase
   end

   // Data registers are not reset; outputs are qualified by their valids so
   // every output reads zero after reset.
   assign cmd_ready_o    = !fifo_full;
   assign issue_valid_o  = (state_q == ST_ISSUE);
   assign issue_instr_o  = issue_valid_o ? issue_instr   : '0;
   assign issue_id_o     = issue_valid_o ? id_q          : '0;
   assign issue_rs1_o    = issue_valid_o ? iss_q.rs1_val : '0;
   assign issue_rs2_o    = issue_valid_o ? iss_q.rs2_val : '0;
   assign commit_valid_o = (state_q == ST_COMMIT);
   assign commit_id_o    = commit_valid_o ? commit_id_q : '0;
   assign commit_kill_o  = 1'b0;
   assign result_ready_o = 1'b1;
   assign rf_we_o        = rf_we_q;
   assign rf_waddr_o     = rf_we_q ? rf_waddr_q : '0;
   assign rf_wdata_o     = rf_we_q ? rf_wdata_q : '0;
   assign rejected_o     = rejected_q;
   assign err_o          = err_q;
   assign busy_o         = !fifo_empty || (state_q != ST_IDLE) || (out_q != '0);

endmodule

// File: tb/tb_fir_xifu_issuer.sv
// -----------------------------------------------------------------------------
// tb_fir_xifu_issuer
// Directed bench for fir_xifu_issuer with hand-computed instruction encodings.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fir_xifu_issuer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_instr;
   logic [4:0]  cmd_rs1, cmd_rs2, cmd_rd;
   logic [11:0] cmd_offset;
   logic [31:0] cmd_rs1_val, cmd_rs2_val;
   logic        issue_valid, issue_ready, issue_accept;
   logic [31:0] issue_instr, issue_rs1, issue_rs2;
   logic [3:0]  issue_id;
   logic        commit_valid, commit_kill;
   logic [3:0]  commit_id;
   logic        result_valid, result_ready, result_we;
   logic [3:0]  result_id;
   logic [4:0]  result_rd;
   logic [31:0] result_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        rejected, err, busy;

   int checks = 0;
   int errors = 0;
   int hs_cnt;

   always #5 clk = ~clk;

   fir_xifu_issuer dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cmd_valid_i    (cmd_valid),
      .cmd_ready_o    (cmd_ready),
      .cmd_instr_i    (cmd_instr),
      .cmd_rs1_i      (cmd_rs1),
      .cmd_rs2_i      (cmd_rs2),
      .cmd_rd_i       (cmd_rd),
      .cmd_offset_i   (cmd_offset),
      .cmd_rs1_val_i  (cmd_rs1_val),
      .cmd_rs2_val_i  (cmd_rs2_val),
      .issue_valid_o  (issue_valid),
      .issue_ready_i  (issue_ready),
      .issue_instr_o  (issue_instr),
      .issue_id_o     (issue_id),
      .issue_rs1_o    (issue_rs1),
      .issue_rs2_o    (issue_rs2),
      .issue_accept_i (issue_accept),
      .commit_valid_o (commit_valid),
      .commit_id_o    (commit_id),
      .commit_kill_o  (commit_kill),
      .result_valid_i (result_valid),
      .result_ready_o (result_ready),
      .result_id_i    (result_id),
      .result_rd_i    (result_rd),
      .result_we_i    (result_we),
      .result_data_i  (result_data),
      .rf_we_o        (rf_we),
      .rf_waddr_o     (rf_waddr),
      .rf_wdata_o     (rf_wdata),
      .rejected_o     (rejected),
      .err_o          (err),
      .busy_o         (busy)
   );

   // Issue handshakes seen on the bus.
   always @(posedge clk) begin
      if (rst) hs_cnt <= 0;
      else if (issue_valid && issue_ready) hs_cnt <= hs_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      cmd_valid    = 1'b0;
      result_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Called on a falling edge; returns on the falling edge after the push.
   task automatic push_cmd(input logic [1:0] instr, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [11:0] off,
                           input logic [31:0] v1, input logic [31:0] v2);
      int n = 0;
      cmd_valid   = 1'b1;
      cmd_instr   = instr;
      cmd_rs1     = rs1;
      cmd_rs2     = rs2;
      cmd_rd      = rd;
      cmd_offset  = off;
      cmd_rs1_val = v1;
      cmd_rs2_val = v2;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_issue();
      int n = 0;
      while (!issue_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("issue_wait", 32'(issue_valid), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_instr = 2'b00; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
      cmd_offset = '0; cmd_rs1_val = '0; cmd_rs2_val = '0;
      issue_ready = 1'b1; issue_accept = 1'b1;
      result_valid = 1'b0; result_id = '0; result_rd = '0; result_we = 1'b0; result_data = '0;

      // Reset state
      do_reset();
      chk("rst_issue_valid",  32'(issue_valid), 0);
      chk("rst_issue_instr",  issue_instr, 0);
      chk("rst_issue_id",     32'(issue_id), 0);
      chk("rst_commit_valid", 32'(commit_valid), 0);
      chk("rst_commit_kill",  32'(commit_kill), 0);
      chk("rst_rf_we",        32'(rf_we), 0);
      chk("rst_rejected",     32'(rejected), 0);
      chk("rst_err",          32'(err), 0);
      chk("rst_busy",         32'(busy), 0);
      chk("rst_cmd_ready",    32'(cmd_ready), 1);
      chk("rst_result_ready", 32'(result_ready), 1);

      // LDTAP rd=5 rs1=10 off=4, then a result writing x7
      push_cmd(2'b00, 5'd10, 5'd0, 5'd5, 12'h004, 32'h1111_1111, 32'h0);
      chk("ldtap_latency", 32'(issue_valid), 0);
      @(negedge clk);
      chk("ldtap_valid", 32'(issue_valid), 1);
      chk("ldtap_instr", issue_instr, 32'h0045_02DB);
      chk("ldtap_id",    32'(issue_id), 0);
      chk("ldtap_rs1",   issue_rs1, 32'h1111_1111);
      @(negedge clk);
      chk("ldtap_commit_valid", 32'(commit_valid), 1);
      chk("ldtap_commit_id",    32'(commit_id), 0);
      chk("ldtap_commit_kill",  32'(commit_kill), 0);
      chk("ldtap_issue_drop",   32'(issue_valid), 0);
      @(negedge clk);
      chk("ldtap_commit_pulse", 32'(commit_valid), 0);
      chk("ldtap_busy_pending", 32'(busy), 1);
      result_valid = 1'b1; result_id = 4'd0; result_rd = 5'd7; result_we = 1'b1;
      result_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("res_rf_we",    32'(rf_we), 1);
      chk("res_rf_waddr", 32'(rf_waddr), 7);
      chk("res_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
      result_valid = 1'b0;
      @(negedge clk);
      chk("res_rf_we_pulse", 32'(rf_we), 0);
      chk("res_idle_busy",   32'(busy), 0);

      // STSAM rs1=2 rs2=3 off=0x07F; result with we=0 must not write
      do_reset();
      push_cmd(2'b11, 5'd2, 5'd3, 5'd0, 12'h07F, 32'h1234_5678, 32'hCAFE_F00D);
      @(negedge clk);
      chk("stsam_instr", issue_instr, 32'h0631_2FDB);
      chk("stsam_rs2",   issue_rs2, 32'hCAFE_F00D);
      chk("stsam_rs1",   issue_rs1, 32'h1234_5678);
      @(negedge clk);
      chk("stsam_commit", 32'(commit_valid), 1);
      @(negedge clk);
      result_valid = 1'b1; result_rd = 5'd4; result_we = 1'b0; result_data = 32'h0;
      @(negedge clk);
      result_valid = 1'b0;
      chk("stsam_no_we", 32'(rf_we), 0);

      // LDSAM rd=1 rs1=1 off=0xFFF held under back-pressure for 5 cycles
      do_reset();
      issue_ready = 1'b0;
      push_cmd(2'b01, 5'd1, 5'd0, 5'd1, 12'hFFF, 32'h0, 32'h0);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk("ldsam_hold_valid", 32'(issue_valid), 1);
         chk("ldsam_hold_instr", issue_instr, 32'hFFF0_90DB);
         chk("ldsam_hold_id",    32'(issue_id), 0);
         if (k < 4) @(negedge clk);
      end
      issue_ready = 1'b1;
      @(negedge clk);
      chk("ldsam_commit",    32'(commit_valid), 1);
      chk("ldsam_commit_id", 32'(commit_id), 0);

      // Reject: pulse, no commit, next command carries ID 1
      do_reset();
      issue_accept = 1'b0;
      push_cmd(2'b00, 5'd10, 5'd0, 5'd5, 12'h004, 32'h0, 32'h0);
      @(negedge clk);
      chk("rej_issue_id", 32'(issue_id), 0);
      @(negedge clk);
      chk("rej_pulse",     32'(rejected), 1);
      chk("rej_no_commit", 32'(commit_valid), 0);
      issue_accept = 1'b1;
      @(negedge clk);
      chk("rej_pulse_end", 32'(rejected), 0);
      chk("rej_not_busy",  32'(busy), 0);
      push_cmd(2'b01, 5'd1, 5'd0, 5'd1, 12'hFFF, 32'h0, 32'h0);
      wait_issue();
      chk("rej_next_id", 32'(issue_id), 1);

      // Outstanding limit: third command waits for a result
      do_reset();
      push_cmd(2'b00, 5'd10, 5'd0, 5'd5, 12'h004, 32'hA, 32'h0);
      push_cmd(2'b01, 5'd1,  5'd0, 5'd1, 12'hFFF, 32'hB, 32'h0);
      push_cmd(2'b00, 5'd4,  5'd0, 5'd3, 12'h010, 32'hC, 32'h0);
      repeat (10) @(negedge clk);
      chk("max_hs_count", 32'(hs_cnt), 2);
      chk("max_held",     32'(issue_valid), 0);
      chk("max_busy",     32'(busy), 1);
      result_valid = 1'b1; result_rd = 5'd0; result_we = 1'b1; result_data = 32'h55;
      @(negedge clk);
      result_valid = 1'b0;
      chk("max_rd0_no_we",   32'(rf_we), 0);
      chk("max_not_yet",     32'(issue_valid), 0);
      wait_issue();
      chk("max_third_id",    32'(issue_id), 2);
      chk("max_third_instr", issue_instr, 32'h0102_01DB);
      chk("max_third_rs1",   issue_rs1, 32'hC);

      // Invalid command and stray result both raise err
      do_reset();
      push_cmd(2'b10, 5'd1, 5'd2, 5'd3, 12'h123, 32'h0, 32'h0);
      @(negedge clk);
      chk("inv_err",      32'(err), 1);
      chk("inv_no_issue", 32'(issue_valid), 0);
      @(negedge clk);
      chk("inv_err_pulse", 32'(err), 0);
      chk("inv_no_issue2", 32'(issue_valid), 0);
      chk("inv_not_busy",  32'(busy), 0);
      result_valid = 1'b1; result_rd = 5'd3; result_we = 1'b1; result_data = 32'h77;
      @(negedge clk);
      result_valid = 1'b0;
      chk("stray_err",   32'(err), 1);
      chk("stray_no_we", 32'(rf_we), 0);

      // Reset while in ISSUE drops everything
      do_reset();
      issue_ready = 1'b0;
      push_cmd(2'b00, 5'd10, 5'd0, 5'd5, 12'h004, 32'h99, 32'h0);
      wait_issue();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_valid",  32'(issue_valid), 0);
      chk("midrst_instr",  issue_instr, 0);
      chk("midrst_rs1",    issue_rs1, 0);
      chk("midrst_commit", 32'(commit_valid), 0);
      chk("midrst_busy",   32'(busy), 0);
      rst = 1'b0;
      issue_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_no_replay", 32'(issue_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
